// File: rtl/mips_defs_pkg.sv
// Shared definitions for the MIPS commit checker.
//   - opcode constants and the HLT idiom (beq rX,rX,-1)
//   - expected-trace entry layout: {pc[31:0], we, wa[4:0], wd[31:0]} = 70 bits
//   - checker state encoding (IDLE=0, RUN=1, DONE=2)
package mips_defs_pkg;

    localparam logic [5:0]  OP_BEQ    = 6'h04;
    localparam logic [15:0] HLT_IMM   = 16'hffff;
    localparam logic [31:0] HLT_INSTR = 32'h1000_ffff;   // beq $0,$0,-1

    // Bit offsets of the fields inside a 70-bit trace entry.
    localparam int ENT_W      = 70;
    localparam int ENT_WD_LSB = 0;
    localparam int ENT_WA_LSB = 32;
    localparam int ENT_WE_BIT = 37;
    localparam int ENT_PC_LSB = 38;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } chk_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
    } trace_entry_t;

    // A branch-to-self with equal operands can only spin: that is the halt idiom.
    function automatic logic is_halt(input logic [31:0] instr);
        return (instr[31:26] == OP_BEQ) && (instr[25:21] == instr[20:16]) &&
               (instr[15:0] == HLT_IMM);
    endfunction

endpackage

// File: rtl/chk_log_fifo.sv
// Mismatch-log FIFO. Stores trace indices of mismatching commits.
//   clk/rst  clock, synchronous active-high reset
//   clr      synchronous flush (checker start)
//   push/din write an entry; dropped when full unless a pop happens the same cycle
//   pop      remove head; ignored when empty
//   valid    FIFO non-empty;  dout  head entry
// DEPTH must be a power of two >= 2.
module chk_log_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic         valid,
    output logic [W-1:0] dout
);
    logic [W-1:0] mem_q [DEPTH];
    logic [PW:0]  wr_q, rd_q;
    logic         empty, full, do_push, do_pop;

    assign empty   = (wr_q == rd_q);
    assign full    = ((wr_q - rd_q) == (PW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign valid   = !empty;
    assign dout    = mem_q[rd_q[PW-1:0]];

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + (PW+1)'(1);
            if (do_pop)  rd_q <= rd_q + (PW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clr) mem_q[wr_q[PW-1:0]] <= din;
    end

endmodule

// File: rtl/mips_commit_checker.sv
// MIPS retire-stream checker. Compares each retired instruction against a
// preloaded expected trace, detects the HLT idiom, and times out hung runs.
//   load_we/load_addr/load_data  trace memory write port (IDLE/DONE only)
//   trace_len, start             run length (latched on start) and start pulse
//   commit_*                     retire stream tap
//   busy/done/pass/timeout       run status
//   err_count/commit_count       saturating statistics
//   first_err_idx                index of first mismatch, all-ones if none
//   log_valid/log_idx/log_pop    mismatch log head (CHECKER_MISMATCH_LOG_EN only)
// Optional feature macro: CHECKER_MISMATCH_LOG_EN (mismatch-index FIFO).
module mips_commit_checker
    import mips_defs_pkg::*;
#(
    parameter int TRACE_DEPTH = 128,
    parameter int TIMEOUT     = 4096,
    parameter int CNT_W       = 16,
    parameter int LOG_DEPTH   = 8,
    localparam int AW         = $clog2(TRACE_DEPTH),
    localparam int IW         = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_we,
    input  logic [AW-1:0]    load_addr,
    input  logic [ENT_W-1:0] load_data,
    input  logic [IW-1:0]    trace_len,
    input  logic             start,
    input  logic             commit_valid,
    input  logic [31:0]      commit_pc,
    input  logic [31:0]      commit_instr,
    input  logic             commit_we,
    input  logic [4:0]       commit_wa,
    input  logic [31:0]      commit_wd,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] commit_count,
    output logic [IW-1:0]    first_err_idx,
    output logic             log_valid,
    output logic [IW-1:0]    log_idx,
    input  logic             log_pop
);
    localparam int TW = $clog2(TIMEOUT) + 1;

    chk_state_e       state_q, state_d;
    trace_entry_t     mem [TRACE_DEPTH];
    trace_entry_t     ent_q, ld_ent;
    logic [IW-1:0]    idx_q, len_q, s1_idx_q, first_q;
    logic [CNT_W-1:0] err_q, cc_q;
    logic [TW-1:0]    cyc_q;
    logic             tmo_q, s1_vld_q, s1_ovr_q, s1_we_q;
    logic [31:0]      s1_pc_q, s1_wd_q;
    logic [4:0]       s1_wa_q;
    logic             run, start_ok, halt_c, tmo_hit, take, mism;

    assign run      = (state_q == ST_RUN);
    assign start_ok = start && !run;
    assign halt_c   = run && commit_valid && is_halt(commit_instr);
    // Halt beats timeout when both land in the same cycle.
    assign tmo_hit  = run && (cyc_q == TW'(TIMEOUT - 1)) && !halt_c;
    // A commit arriving in the cycle RUN times out is not part of the run.
    assign take     = run && commit_valid && !halt_c && !tmo_hit;

    assign ld_ent = '{pc: load_data[ENT_PC_LSB +: 32], we: load_data[ENT_WE_BIT],
                      wa: load_data[ENT_WA_LSB +: 5],  wd: load_data[ENT_WD_LSB +: 32]};

    // wd only matters when the expected write actually lands ($0 is hardwired).
    assign mism = s1_ovr_q || (ent_q.pc != s1_pc_q) || (ent_q.we != s1_we_q) ||
                  (ent_q.wa != s1_wa_q) ||
                  (ent_q.we && (ent_q.wa != 5'd0) && (ent_q.wd != s1_wd_q));

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start)            state_d = ST_RUN;
            ST_RUN:  if (halt_c || tmo_hit) state_d = ST_DONE;
            ST_DONE: if (start)            state_d = ST_RUN;
            default:                       state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Two-stage compare: stage 1 registers the commit while the trace entry is
    // read synchronously; stage 2 compares and updates the statistics.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q    <= '0;
            len_q    <= '0;
            err_q    <= '0;
            cc_q     <= '0;
            cyc_q    <= '0;
            tmo_q    <= 1'b0;
            first_q  <= '1;
            s1_vld_q <= 1'b0;
            s1_ovr_q <= 1'b0;
            s1_idx_q <= '0;
        end else if (start_ok) begin
            idx_q    <= '0;
            len_q    <= trace_len;
            err_q    <= '0;
            cc_q     <= '0;
            cyc_q    <= '0;
            tmo_q    <= 1'b0;
            first_q  <= '1;
            s1_vld_q <= 1'b0;
        end else begin
            if (run)     cyc_q <= cyc_q + TW'(1);
            if (tmo_hit) tmo_q <= 1'b1;
            s1_vld_q <= take;
            if (take) begin
                s1_idx_q <= idx_q;
                s1_ovr_q <= (idx_q >= len_q) || (idx_q >= IW'(TRACE_DEPTH));
                if (idx_q != IW'(TRACE_DEPTH)) idx_q <= idx_q + IW'(1);
            end
            if (s1_vld_q) begin
                if (~&cc_q) cc_q <= cc_q + CNT_W'(1);
                if (mism) begin
                    if (~&err_q)       err_q   <= err_q + CNT_W'(1);
                    if (err_q == '0)   first_q <= s1_idx_q;
                end
            end
        end
    end

    // Trace memory and datapath captures are intentionally not reset.
    always_ff @(posedge clk) begin
        if (load_we && !run) mem[load_addr] <= ld_ent;
        if (take) begin
            ent_q   <= mem[idx_q[AW-1:0]];
            s1_pc_q <= commit_pc;
            s1_we_q <= commit_we;
            s1_wa_q <= commit_wa;
            s1_wd_q <= commit_wd;
        end
    end

    assign busy          = run;
    assign done          = (state_q == ST_DONE);
    assign pass          = done && (err_q == '0) && (idx_q == len_q) && !tmo_q;
    assign timeout       = tmo_q;
    assign err_count     = err_q;
    assign commit_count  = cc_q;
    assign first_err_idx = first_q;

`ifdef CHECKER_MISMATCH_LOG_EN
    chk_log_fifo #(.DEPTH(LOG_DEPTH), .W(IW)) u_log (
        .clk   (clk),
        .rst   (rst),
        .clr   (start_ok),
        .push  (s1_vld_q && mism),
        .din   (s1_idx_q),
        .pop   (log_pop),
        .valid (log_valid),
        .dout  (log_idx)
    );
`else
    localparam int unused_log_depth = LOG_DEPTH;
    logic unused_log_pop;
    assign unused_log_pop = log_pop;
    assign log_valid      = 1'b0;
    assign log_idx        = '0;
`endif

endmodule

// File: tb/tb_mips_commit_checker.sv
// Scoreboard bench for mips_commit_checker: each run pushes its expected
// end-of-run result; a monitor pops and compares on every rising edge of done.
module tb_mips_commit_checker;
    import mips_defs_pkg::*;

    localparam int AW = 7;
    localparam int IW = 8;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst, load_we, start, commit_valid, commit_we, log_pop;
    logic [AW-1:0] load_addr;
    logic [69:0]   load_data;
    logic [IW-1:0] trace_len;
    logic [31:0]   commit_pc, commit_instr, commit_wd;
    logic [4:0]    commit_wa;
    logic          busy, done, pass, timeout, log_valid;
    logic [CW-1:0] err_count, commit_count;
    logic [IW-1:0] first_err_idx, log_idx;

    mips_commit_checker #(.TRACE_DEPTH(128), .TIMEOUT(64), .CNT_W(CW), .LOG_DEPTH(8)) dut (
        .clk(clk), .rst(rst), .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
        .trace_len(trace_len), .start(start), .commit_valid(commit_valid),
        .commit_pc(commit_pc), .commit_instr(commit_instr), .commit_we(commit_we),
        .commit_wa(commit_wa), .commit_wd(commit_wd), .busy(busy), .done(done), .pass(pass),
        .timeout(timeout), .err_count(err_count), .commit_count(commit_count),
        .first_err_idx(first_err_idx), .log_valid(log_valid), .log_idx(log_idx),
        .log_pop(log_pop)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic pass;
        logic tmo;
        int   err;
        int   cc;
        int   first;
        int   lat;      // cycles from start edge to done, -1 = not checked
        int   st_cyc;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc_cnt = 0;
    int   last_start = 0;
    logic done_d = 1'b0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string nm, input longint act, input longint expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    // Monitor: result compare on each new done.
    always @(negedge clk) begin
        if (rst) begin
            done_d <= 1'b0;
        end else begin
            if (done && !done_d) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("pass", pass, e.pass);
                    chk("timeout", timeout, e.tmo);
                    chk("err_count", err_count, e.err);
                    chk("commit_count", commit_count, e.cc);
                    chk("first_err_idx", first_err_idx, e.first);
                    chk("busy_at_done", busy, 0);
                    if (e.lat >= 0) chk("done_latency", cyc_cnt - e.st_cyc, e.lat);
                end
            end
            done_d <= done;
        end
    end

    task automatic expect_run(input logic p, input logic t, input int e, input int c,
                              input int f, input int lat);
        exp_t x;
        x.pass = p; x.tmo = t; x.err = e; x.cc = c; x.first = f; x.lat = lat;
        x.st_cyc = last_start;
        exp_q.push_back(x);
    endtask

    task automatic load(input int a, input logic [31:0] pc, input logic we,
                        input logic [4:0] wa, input logic [31:0] wd);
        @(negedge clk);
        load_we = 1'b1; load_addr = AW'(a); load_data = {pc, we, wa, wd};
        @(negedge clk);
        load_we = 1'b0;
    endtask

    // Standard trace: ORI v0 writes of 5,6,7 at pc 0,4,8.
    task automatic load_std();
        for (int i = 0; i < 3; i++) load(i, 32'(4 * i), 1'b1, 5'd2, 32'(5 + i));
    endtask

    task automatic do_start(input int len);
        @(negedge clk);
        start = 1'b1; trace_len = IW'(len);
        last_start = cyc_cnt + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic cmt(input logic [31:0] pc, input logic [31:0] instr, input logic we,
                       input logic [4:0] wa, input logic [31:0] wd);
        @(negedge clk);
        commit_valid = 1'b1; commit_pc = pc; commit_instr = instr;
        commit_we = we; commit_wa = wa; commit_wd = wd;
    endtask

    task automatic idle();
        @(negedge clk);
        commit_valid = 1'b0;
    endtask

    task automatic halt_cmt(input logic [31:0] pc);
        cmt(pc, HLT_INSTR, 1'b0, 5'd0, 32'd0);
        idle();
    endtask

    task automatic wait_done(input int lim);
        int n = 0;
        while (!done && n < lim) begin
            @(negedge clk);
            n++;
        end
        if (!done) chk("done_wait_expired", 0, 1);
        @(negedge clk);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_pass"}, pass, 0);
        chk({tag, "_timeout"}, timeout, 0);
        chk({tag, "_err"}, err_count, 0);
        chk({tag, "_cc"}, commit_count, 0);
        chk({tag, "_first"}, first_err_idx, 255);
        chk({tag, "_log_valid"}, log_valid, 0);
        chk({tag, "_log_idx"}, log_idx, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; load_we = 1'b0; load_addr = '0; load_data = '0; trace_len = '0;
        start = 1'b0; commit_valid = 1'b0; commit_pc = '0; commit_instr = '0;
        commit_we = 1'b0; commit_wa = '0; commit_wd = '0; log_pop = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_reset_state("reset");

        // 1: exact trace then HLT
        load_std();
        do_start(3);
        expect_run(1'b1, 1'b0, 0, 3, 255, -1);
        for (int i = 0; i < 3; i++)
            cmt(32'(4 * i), 32'h3402_0005 + 32'(i), 1'b1, 5'd2, 32'(5 + i));
        halt_cmt(32'd12);
        wait_done(20);

        // 2: commit 1 writes 0x5 instead of 0x6
        do_start(3);
        expect_run(1'b0, 1'b0, 1, 3, 1, -1);
        cmt(32'd0, 32'h3402_0005, 1'b1, 5'd2, 32'd5);
        cmt(32'd4, 32'h3402_0005, 1'b1, 5'd2, 32'd5);
        cmt(32'd8, 32'h3402_0007, 1'b1, 5'd2, 32'd7);
        halt_cmt(32'd12);
        wait_done(20);
`ifndef CHECKER_MISMATCH_LOG_EN
        @(negedge clk) log_pop = 1'b1;
        @(negedge clk) log_pop = 1'b0;
        chk("nolog_valid", log_valid, 0);
        chk("nolog_idx", log_idx, 0);
`endif

        // 3: write to $0 with junk data is not compared
        load(0, 32'h20, 1'b1, 5'd0, 32'd0);
        do_start(1);
        expect_run(1'b1, 1'b0, 0, 1, 255, -1);
        cmt(32'h20, 32'h3400_1234, 1'b1, 5'd0, 32'hdead_beef);
        halt_cmt(32'h24);
        wait_done(20);

        // 4: no HLT -> timeout 64 cycles after start
        do_start(3);
        expect_run(1'b0, 1'b1, 0, 0, 255, 64);
        wait_done(200);

        // 4b: reset in the middle of a run
        do_start(3);
        cmt(32'h100, 32'h3402_0005, 1'b1, 5'd2, 32'd5);
        idle();
        @(negedge clk);
        chk("midrun_busy", busy, 1);
        chk("midrun_err", err_count, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset_state("midrst");

        // 5: len=2, four commits -> two overruns
        load_std();
        do_start(2);
        expect_run(1'b0, 1'b0, 2, 4, 2, -1);
        for (int i = 0; i < 4; i++)
            cmt(32'(4 * i), 32'h3402_0005, 1'b1, 5'd2, 32'(5 + i));
        halt_cmt(32'd16);
        wait_done(20);

        // 5b: early HLT after one good commit
        do_start(3);
        expect_run(1'b0, 1'b0, 0, 1, 255, -1);
        cmt(32'd0, 32'h3402_0005, 1'b1, 5'd2, 32'd5);
        halt_cmt(32'd4);
        wait_done(20);

        // HLT on the very cycle the timeout would fire: halt wins
        do_start(0);
        expect_run(1'b1, 1'b0, 0, 0, 255, 64);
        repeat (62) @(negedge clk);
        halt_cmt(32'd0);
        wait_done(20);

`ifdef CHECKER_MISMATCH_LOG_EN
        // 6: ten mismatches into an 8-deep log
        for (int i = 0; i < 10; i++) load(i, 32'(4 * i), 1'b1, 5'd2, 32'(i));
        do_start(10);
        expect_run(1'b0, 1'b0, 10, 10, 0, -1);
        for (int i = 0; i < 10; i++) cmt(32'(4 * i + 1), 32'h3402_0000, 1'b1, 5'd2, 32'(i));
        halt_cmt(32'd40);
        wait_done(20);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("log_valid", log_valid, 1);
            chk("log_idx", log_idx, i);
            log_pop = 1'b1;
        end
        @(negedge clk);
        log_pop = 1'b0;
        chk("log_drained", log_valid, 0);
`endif

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
